// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator sequencer: opcodes, reject codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

    // Command opcodes; encodings 8..15 are not listed and decode as illegal.
    typedef enum logic [3:0] {
        OP_DIGIT = 4'd0,
        OP_ENTER = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_MUL   = 4'd4,
        OP_DROP  = 4'd5,
        OP_SWAP  = 4'd6,
        OP_CLEAR = 4'd7
    } opcode_t;

    // Reject reasons reported on err_code alongside the err pulse.
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    // Sequencer states; each non-IDLE state owns exactly one stack strobe.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_WR   = 3'd2,
        ST_PUSH = 3'd3,
        ST_WR2  = 3'd4,
        ST_CLR  = 3'd5
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic for the RPN sequencer: digit entry, add, sub and optional multiply.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
// Ports: a_i (second-from-top), b_i (top), op_i (opcode), digit_i (entry digit) -> result_o.
// Build option RPN_MUL_EN: when defined, OP_MUL yields the low 32 bits of a*b; otherwise
// no multiplier is built and OP_MUL returns 0 (the sequencer rejects it before use).
module rpn_alu
    import calc_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  opcode_t     op_i,
    input  logic [3:0]  digit_i,
    output logic [31:0] result_o
);

    localparam logic [31:0] RADIX_W = 32'(RADIX);

    always_comb begin
        result_o = '0;
        case (op_i)
            // Shift the current top one place left in the entry base, then add the digit.
            OP_DIGIT: result_o = (b_i * RADIX_W) + {28'd0, digit_i};
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
`ifdef RPN_MUL_EN
            OP_MUL:   result_o = a_i * b_i;
`endif
            // DROP on a single element writes 0, which is the default result.
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Command sequencer for an RPN calculator: turns one command into a strobe sequence on an external stack.
// Latency: accept-to-done 1 cycle (DIGIT/ENTER/DROP/CLEAR), 2 (ADD/SUB/MUL), 4 (SWAP); rejects pulse err 1 cycle after accept.
// Backpressure: cmd_ready is high only in IDLE and low while reset is high; command accepted on cmd_valid && cmd_ready.
// Ports: clock/reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_digit command handshake;
//        stk_push/stk_pop/stk_write/stk_clear/stk_value to the stack; stk_top/stk_next/stk_count/stk_error from it;
//        done/err/err_code completion status; ovf_sticky latched stack error.
// Build option RPN_MUL_EN: enables MUL (opcode 4); without it opcode 4 is rejected as illegal.
module rpn_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_digit,
    output logic        stk_push,
    output logic        stk_pop,
    output logic        stk_write,
    output logic [31:0] stk_value,
    output logic        stk_clear,
    input  logic [31:0] stk_top,
    input  logic [31:0] stk_next,
    input  logic [5:0]  stk_count,
    input  logic        stk_error,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        ovf_sticky
);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    opcode_t     op_q, op_d;
    logic [3:0]  digit_q, digit_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        ovf_q, ovf_d;

    opcode_t     cmd_opc;
    logic        one_elem;
    logic        full;
    logic [31:0] alu_res;

    logic        push_raw, pop_raw, write_raw, clear_raw, done_raw;
    logic [31:0] value_raw;

    assign cmd_opc  = opcode_t'(cmd_op);
    // A count of 0 means 64 entries, so 0 is "full" and 1 is the only underflow depth.
    assign one_elem = (stk_count == 6'd1);
    assign full     = (stk_count == 6'd0);

    rpn_alu #(
        .RADIX (RADIX)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .digit_i  (digit_q),
        .result_o (alu_res)
    );

    // Next-state, operand latching and reject decode.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        digit_d    = digit_q;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_d     = stk_next;
                    b_d     = stk_top;
                    op_d    = cmd_opc;
                    digit_d = cmd_digit;
                    case (cmd_opc)
                        OP_DIGIT: state_d = ST_WR;
                        OP_ENTER: begin
                            if (full) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_OVERFLOW;
                            end else begin
                                state_d = ST_PUSH;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (one_elem) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNDERFLOW;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
`ifdef RPN_MUL_EN
                        OP_MUL: begin
                            if (one_elem) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNDERFLOW;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
`endif
                        // The last element is never popped; it is zeroed instead.
                        OP_DROP:  state_d = one_elem ? ST_WR : ST_POP;
                        OP_SWAP: begin
                            if (one_elem) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNDERFLOW;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
                        OP_CLEAR: state_d = ST_CLR;
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_POP:  state_d = (op_q == OP_DROP) ? ST_IDLE : ST_WR;
            ST_WR:   state_d = (op_q == OP_SWAP) ? ST_PUSH : ST_IDLE;
            ST_PUSH: state_d = (op_q == OP_SWAP) ? ST_WR2  : ST_IDLE;
            ST_WR2:  state_d = ST_IDLE;
            ST_CLR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // CLEAR wins over a coincident stack error.
        ovf_d = ovf_q;
        if (state_q == ST_CLR) begin
            ovf_d = 1'b0;
        end else if (stk_error) begin
            ovf_d = 1'b1;
        end
    end

    // Strobes and done come straight from the registered state.
    always_comb begin
        push_raw  = 1'b0;
        pop_raw   = 1'b0;
        write_raw = 1'b0;
        clear_raw = 1'b0;
        done_raw  = 1'b0;
        value_raw = '0;

        case (state_q)
            ST_POP: begin
                pop_raw  = 1'b1;
                done_raw = (op_q == OP_DROP);
            end
            ST_WR: begin
                write_raw = 1'b1;
                // SWAP first writes the old top back; every other op writes the ALU result.
                value_raw = (op_q == OP_SWAP) ? b_q : alu_res;
                done_raw  = (op_q != OP_SWAP);
            end
            ST_PUSH: begin
                push_raw = 1'b1;
                done_raw = (op_q != OP_SWAP);
            end
            ST_WR2: begin
                write_raw = 1'b1;
                value_raw = a_q;
                done_raw  = 1'b1;
            end
            ST_CLR: begin
                clear_raw = 1'b1;
                done_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks outputs in the same cycle so an interrupted command emits nothing further.
    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign stk_push   = push_raw  && !reset;
    assign stk_pop    = pop_raw   && !reset;
    assign stk_write  = write_raw && !reset;
    assign stk_clear  = clear_raw && !reset;
    assign stk_value  = reset ? 32'd0 : value_raw;
    assign done       = done_raw  && !reset;
    assign err        = err_q     && !reset;
    assign err_code   = reset ? ERR_NONE : err_code_q;
    assign ovf_sticky = ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_DIGIT;
            digit_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            digit_q    <= digit_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer with a behavioural 64-entry stack.
// Expected stack-side events are queued per command; a negedge monitor pops and compares them.
module tb_rpn_sequencer;
    import calc_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [3:0]  cmd_digit = 4'd0;
    logic        stk_push, stk_pop, stk_write, stk_clear;
    logic [31:0] stk_value;
    logic [31:0] top_r = 32'd0;
    logic [31:0] next_r = 32'd0;
    logic [5:0]  cnt_r = 6'd1;
    logic        force_err = 1'b0;
    logic        done, err;
    logic [1:0]  err_code;
    logic        ovf_sticky;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = 0;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_PUSH = 4'b1000;
    localparam logic [3:0] S_POP  = 4'b0100;
    localparam logic [3:0] S_WR   = 4'b0010;
    localparam logic [3:0] S_CLR  = 4'b0001;

    typedef struct {
        logic [3:0]  strb;
        logic [31:0] val;
        logic        dn;
        logic        er;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    exp_t m_e;
    logic [3:0] got_strb;

    rpn_sequencer #(.RADIX(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_digit  (cmd_digit),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_write  (stk_write),
        .stk_value  (stk_value),
        .stk_clear  (stk_clear),
        .stk_top    (top_r),
        .stk_next   (next_r),
        .stk_count  (cnt_r),
        .stk_error  (force_err),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural stack: starts with a single zero entry; push adds a zero.
    logic [31:0] stk[$];
    int sz;
    initial stk.push_back(32'd0);
    always @(posedge clock) begin
        if (reset || stk_clear) begin
            stk = {};
            stk.push_back(32'd0);
        end else if (stk_push) begin
            if (stk.size() < 64) stk.push_back(32'd0);
        end else if (stk_pop) begin
            if (stk.size() > 1) void'(stk.pop_back());
        end else if (stk_write) begin
            stk[stk.size() - 1] = stk_value;
        end
        sz = stk.size();
        top_r  <= stk[sz - 1];
        next_r <= (sz > 1) ? stk[sz - 2] : 32'd0;
        cnt_r  <= 6'(sz);
    end

    // Monitor: every cycle with any stack strobe or status pulse must match the next expected event.
    always @(negedge clock) begin
        got_strb = {stk_push, stk_pop, stk_write, stk_clear};
        if (got_strb != 4'b0000 || done || err) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d strb=%b val=%h done=%b err=%b code=%0d",
                         cyc, got_strb, stk_value, done, err, err_code);
            end else begin
                m_e = expq.pop_front();
                if (got_strb !== m_e.strb || done !== m_e.dn || err !== m_e.er ||
                    err_code !== m_e.code || cyc != m_e.cyc ||
                    (m_e.strb[1] && stk_value !== m_e.val)) begin
                    failures++;
                    $display("FAIL event got cyc=%0d strb=%b val=%h done=%b err=%b code=%0d want cyc=%0d strb=%b val=%h done=%b err=%b code=%0d",
                             cyc, got_strb, stk_value, done, err, err_code,
                             m_e.cyc, m_e.strb, m_e.val, m_e.dn, m_e.er, m_e.code);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Event expected `off` cycles after the accept edge of the current command.
    task automatic ex(input int off, input logic [3:0] strb, input logic [31:0] val,
                      input logic dn, input logic er, input logic [1:0] code);
        exp_t e;
        e.strb = strb; e.val = val; e.dn = dn; e.er = er; e.code = code; e.cyc = acc + off;
        expq.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] dig);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_digit = dig;
        acc       = cyc + 1;
    endtask

    task automatic go();
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("drain", expq.size(), 32'd0);
        @(negedge clock);
    endtask

    task automatic digit(input logic [3:0] d, input logic [31:0] want_top);
        issue(OP_DIGIT, d); ex(0, S_WR, want_top, 1, 0, 0); go(); drain();
    endtask

    task automatic enter();
        issue(OP_ENTER, 0); ex(0, S_PUSH, 0, 1, 0, 0); go(); drain();
    endtask

    task automatic clear();
        issue(OP_CLEAR, 0); ex(0, S_CLR, 0, 1, 0, 0); go(); drain();
    endtask

    task automatic binop(input logic [3:0] op, input logic [31:0] res);
        issue(op, 0); ex(0, S_POP, 0, 0, 0, 0); ex(1, S_WR, res, 1, 0, 0); go(); drain();
    endtask

    task automatic reject(input logic [3:0] op, input logic [1:0] code);
        issue(op, 0); ex(0, S_NONE, 0, 0, 1, code); go(); drain();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_strobes", {28'd0, stk_push, stk_pop, stk_write, stk_clear}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Digit entry: 4 then 2 builds 42
        digit(4, 32'd4);
        digit(2, 32'd42);
        chk("digit_top", top_r, 32'd42);
        chk("digit_count", {26'd0, cnt_r}, 32'd1);

        // 7 ENTER 5 SUB -> 2
        clear();
        digit(7, 32'd7); enter(); digit(5, 32'd5);
        binop(OP_SUB, 32'd2);
        chk("sub_top", top_r, 32'd2);
        chk("sub_count", {26'd0, cnt_r}, 32'd1);

        // 3 ENTER 5 SUB wraps
        clear();
        digit(3, 32'd3); enter(); digit(5, 32'd5);
        binop(OP_SUB, 32'hFFFF_FFFE);
        chk("sub_wrap_top", top_r, 32'hFFFF_FFFE);

        // 7 ENTER 5 ADD -> 12
        clear();
        digit(7, 32'd7); enter(); digit(5, 32'd5);
        binop(OP_ADD, 32'd12);
        chk("add_top", top_r, 32'd12);

        // Multiply, or its rejection when not built in
        clear();
        digit(6, 32'd6); enter(); digit(7, 32'd7);
`ifdef RPN_MUL_EN
        binop(OP_MUL, 32'd42);
        chk("mul_top", top_r, 32'd42);
`else
        reject(OP_MUL, ERR_ILLEGAL);
        chk("mul_rej_top", top_r, 32'd7);
`endif

        // Binary op on a single element
        clear();
        reject(OP_ADD, ERR_UNDERFLOW);
        chk("underflow_top", top_r, 32'd0);
        chk("underflow_count", {26'd0, cnt_r}, 32'd1);

        // Illegal opcodes
        reject(4'd9, ERR_ILLEGAL);
        reject(4'd15, ERR_ILLEGAL);

        // 1 ENTER 2 SWAP -> POP, WR(2), PUSH, WR2(1)
        clear();
        digit(1, 32'd1); enter(); digit(2, 32'd2);
        issue(OP_SWAP, 0);
        ex(0, S_POP, 0, 0, 0, 0);
        ex(1, S_WR, 32'd2, 0, 0, 0);
        ex(2, S_PUSH, 0, 0, 0, 0);
        ex(3, S_WR, 32'd1, 1, 0, 0);
        go(); drain();
        chk("swap_top", top_r, 32'd1);
        chk("swap_next", next_r, 32'd2);
        chk("swap_count", {26'd0, cnt_r}, 32'd2);

        // DROP at depth 2 pops; at depth 1 zeroes; SWAP at depth 1 rejects
        issue(OP_DROP, 0); ex(0, S_POP, 0, 1, 0, 0); go(); drain();
        chk("drop2_top", top_r, 32'd2);
        chk("drop2_count", {26'd0, cnt_r}, 32'd1);
        issue(OP_DROP, 0); ex(0, S_WR, 32'd0, 1, 0, 0); go(); drain();
        chk("drop1_top", top_r, 32'd0);
        reject(OP_SWAP, ERR_UNDERFLOW);

        // Fill to 64 entries, then overflow
        clear();
        for (int i = 0; i < 63; i++) enter();
        chk("full_count", {26'd0, cnt_r}, 32'd0);
        reject(OP_ENTER, ERR_OVERFLOW);
        chk("full_count_after", {26'd0, cnt_r}, 32'd0);

        // Sticky stack error
        chk("ovf_before", {31'd0, ovf_sticky}, 32'd0);
        force_err = 1'b1;
        @(negedge clock);
        force_err = 1'b0;
        @(negedge clock);
        chk("ovf_set", {31'd0, ovf_sticky}, 32'd1);
        repeat (3) @(negedge clock);
        chk("ovf_hold", {31'd0, ovf_sticky}, 32'd1);
        clear();
        chk("ovf_cleared", {31'd0, ovf_sticky}, 32'd0);

        // Reset during the POP of a SWAP: nothing more may come out
        digit(1, 32'd1); enter(); digit(2, 32'd2);
        issue(OP_SWAP, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge clock);
        chk("midrst_quiet", expq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
